// File: rtl/arki_enc_pkg.sv
// Shared types and packing helpers for the LEGv8 instruction encoder.
package arki_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_D  = 3'd2,
        FMT_CB = 3'd3,
        FMT_B  = 3'd4
    } fmt_t;

    localparam int IMM_W_I  = 12;
    localparam int IMM_W_D  = 9;
    localparam int IMM_W_CB = 19;
    localparam int IMM_W_B  = 26;
    localparam int SHAMT_W  = 6;

    // True when v, read as two's complement, fits in a signed field of w bits:
    // every bit from w-1 upward must equal the sign bit.
    function automatic logic fits_signed(input logic [63:0] v, input int unsigned w);
        logic [63:0] s;
        s = 64'($signed(v) >>> (w - 32'd1));
        return (s == 64'd0) || (s == {64{1'b1}});
    endfunction

    function automatic logic [31:0] pack_r(input logic [10:0] op, input logic [4:0] rm,
                                           input logic [SHAMT_W-1:0] shamt,
                                           input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, shamt, rn, rd};
    endfunction

    function automatic logic [31:0] pack_i(input logic [9:0] op_hi, input logic [IMM_W_I-1:0] imm,
                                           input logic [4:0] rn, input logic [4:0] rd);
        return {op_hi, imm, rn, rd};
    endfunction

    function automatic logic [31:0] pack_d(input logic [10:0] op, input logic [IMM_W_D-1:0] imm,
                                           input logic [4:0] rn, input logic [4:0] rd);
        return {op, imm, 2'b00, rn, rd};
    endfunction

    function automatic logic [31:0] pack_cb(input logic [7:0] op_hi, input logic [IMM_W_CB-1:0] imm,
                                            input logic [4:0] rd);
        return {op_hi, imm, rd};
    endfunction

    function automatic logic [31:0] pack_b(input logic [5:0] op_hi, input logic [IMM_W_B-1:0] imm);
        return {op_hi, imm};
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational check that an immediate fits the field of its format.
module imm_range_check
    import arki_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [63:0] imm,
    output logic        fits,
    output logic        illegal_fmt
);

    fmt_t w_fmt;
    assign w_fmt = fmt_t'(fmt);

    // Select the field width of the format and test the immediate against it
    always_comb begin
        fits        = 1'b0;
        illegal_fmt = 1'b0;
        case (w_fmt)
            FMT_R:   fits = ~|imm[63:SHAMT_W];
            FMT_I:   fits = fits_signed(imm, IMM_W_I);
            FMT_D:   fits = fits_signed(imm, IMM_W_D);
            FMT_CB:  fits = fits_signed(imm, IMM_W_CB);
            FMT_B:   fits = fits_signed(imm, IMM_W_B);
            default: illegal_fmt = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded LEGv8 fields into instruction words and streams them into
// instruction memory at an auto-incrementing, saturating word address.
module instr_encoder
    import arki_enc_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    fmt,
    input  logic [10:0]   opcode,
    input  logic [63:0]   imm,
    input  logic [4:0]    rn,
    input  logic [4:0]    rm,
    input  logic [4:0]    rd,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          range_err,
    output logic          err_pulse,
    output logic          full,
    output logic [AW:0]   count
);

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_FULL   = 1'b1
    } state_t;

    localparam logic [AW:0] L_DEPTH = (AW + 1)'(DEPTH);

    state_t        r_state;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [31:0]   r_wr_data;
    logic          r_range_err;
    logic          r_err_pulse;
    logic          r_full;
    logic [AW:0]   r_count;

    fmt_t          w_fmt;
    logic          w_fits;
    logic          w_illegal_fmt;
    logic [31:0]   w_word;
    logic [AW:0]   w_count_inc;

    assign w_fmt       = fmt_t'(fmt);
    assign w_count_inc = r_count + {{AW{1'b0}}, 1'b1};

    imm_range_check u_range (
        .fmt         (fmt),
        .imm         (imm),
        .fits        (w_fits),
        .illegal_fmt (w_illegal_fmt)
    );

    // Build the instruction word for the presented format
    always_comb begin
        w_word = 32'd0;
        case (w_fmt)
            FMT_R:   w_word = pack_r(opcode, rm, imm[SHAMT_W-1:0], rn, rd);
            FMT_I:   w_word = pack_i(opcode[10:1], imm[IMM_W_I-1:0], rn, rd);
            FMT_D:   w_word = pack_d(opcode, imm[IMM_W_D-1:0], rn, rd);
            FMT_CB:  w_word = pack_cb(opcode[10:3], imm[IMM_W_CB-1:0], rd);
            FMT_B:   w_word = pack_b(opcode[10:5], imm[IMM_W_B-1:0]);
            default: w_word = 32'd0;
        endcase
    end

    // Accept/full FSM: one transfer per cycle, write issued the following cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_ACCEPT;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= {AW{1'b0}};
            r_wr_data   <= 32'd0;
            r_range_err <= 1'b0;
            r_err_pulse <= 1'b0;
            r_full      <= 1'b0;
            r_count     <= {(AW + 1){1'b0}};
        end else if (clear) begin
            // Any write in flight has already had its strobe cycle; the
            // concurrent transfer was refused because in_ready is low.
            r_state     <= ST_ACCEPT;
            r_wr_en     <= 1'b0;
            r_range_err <= 1'b0;
            r_err_pulse <= 1'b0;
            r_full      <= 1'b0;
            r_count     <= {(AW + 1){1'b0}};
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    r_wr_en     <= 1'b0;
                    r_err_pulse <= 1'b0;
                    if (in_valid) begin
                        if (w_fits && !w_illegal_fmt) begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= w_word;
                            r_wr_addr <= r_count[AW-1:0];
                            r_count   <= w_count_inc;
                            if (w_count_inc == L_DEPTH) begin
                                r_full  <= 1'b1;
                                r_state <= ST_FULL;
                            end else begin
                                r_full  <= 1'b0;
                            end
                        end else begin
                            // Rejected transfer: consumed, flagged, pointer held
                            r_err_pulse <= 1'b1;
                            r_range_err <= 1'b1;
                        end
                    end else begin
                        r_wr_en <= 1'b0;
                    end
                end
                ST_FULL: begin
                    r_wr_en     <= 1'b0;
                    r_err_pulse <= 1'b0;
                end
                default: begin
                    r_state     <= ST_ACCEPT;
                    r_wr_en     <= 1'b0;
                    r_err_pulse <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACCEPT) && !clear;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign range_err = r_range_err;
    assign err_pulse = r_err_pulse;
    assign full      = r_full;
    assign count     = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written
// corner sequences and a randomized run against a field-arithmetic model.
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    localparam logic [10:0] OP_R  = 11'b10001011000;
    localparam logic [10:0] OP_I  = 11'b10010001000;
    localparam logic [10:0] OP_D  = 11'b11111000010;
    localparam logic [10:0] OP_CB = 11'b10110100000;
    localparam logic [10:0] OP_B  = 11'b00010100000;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    fmt;
    logic [10:0]   opcode;
    logic [63:0]   imm;
    logic [4:0]    rn;
    logic [4:0]    rm;
    logic [4:0]    rd;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          range_err;
    logic          err_pulse;
    logic          full;
    logic [AW:0]   count;

    int tests = 0;
    int fails = 0;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .imm       (imm),
        .rn        (rn),
        .rm        (rm),
        .rd        (rd),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .range_err (range_err),
        .err_pulse (err_pulse),
        .full      (full),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [10:0] op;
        longint      imm;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [4:0]  rd;
        bit          ok;
        logic [31:0] word;
    } vec_t;

    vec_t vt[21];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: inputs were driven after a falling edge, outputs read at the next one
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [2:0] f, input logic [10:0] op,
                         input longint im, input logic [4:0] n, input logic [4:0] m,
                         input logic [4:0] d);
        in_valid = v;
        fmt      = f;
        opcode   = op;
        imm      = im;
        rn       = n;
        rm       = m;
        rd       = d;
    endtask

    task automatic pulse_clear();
        in_valid = 1'b0;
        clear    = 1'b1;
        step();
        clear    = 1'b0;
    endtask

    // Reference encoding from the format rules using plain integer arithmetic
    function automatic void model_encode(input int f, input logic [10:0] op, input longint im,
                                         input int n, input int m, input int d,
                                         output bit ok, output logic [31:0] w);
        int     width;
        longint lo, hi, field, o, r;
        o = longint'(op);
        case (f)
            0: width = 6;
            1: width = 12;
            2: width = 9;
            3: width = 19;
            4: width = 26;
            default: width = 12;
        endcase
        if (f == 0) begin
            lo = 0;
            hi = 63;
        end else begin
            lo = -(longint'(1) << (width - 1));
            hi = (longint'(1) << (width - 1)) - 1;
        end
        ok    = (f <= 4) && (im >= lo) && (im <= hi);
        field = im & ((longint'(1) << width) - 1);
        case (f)
            0: r = o * 2097152 + m * 65536 + field * 1024 + n * 32 + d;
            1: r = (o / 2) * 4194304 + field * 1024 + n * 32 + d;
            2: r = o * 2097152 + field * 4096 + n * 32 + d;
            3: r = (o / 8) * 16777216 + field * 32 + d;
            4: r = (o / 32) * 67108864 + field;
            default: r = 0;
        endcase
        w = 32'(r);
    endfunction

    initial begin
        int     m_count;
        bit     m_full;
        bit     m_rerr;
        bit     ok;
        logic [31:0] w;

        vt[0]  = '{3'd3, OP_CB, -64'sd23,       5'd0, 5'd0, 5'd1,  1'b1, 32'hB4FFFD21};
        vt[1]  = '{3'd2, OP_D,  64'sd23,        5'd0, 5'd0, 5'd1,  1'b1, 32'hF8417001};
        vt[2]  = '{3'd1, OP_I,  64'sd23,        5'd1, 5'd0, 5'd1,  1'b1, 32'h91005C21};
        vt[3]  = '{3'd2, OP_D,  64'sd256,       5'd0, 5'd0, 5'd1,  1'b0, 32'h0};
        vt[4]  = '{3'd2, OP_D,  -64'sd256,      5'd0, 5'd0, 5'd1,  1'b1, 32'hF8500001};
        vt[5]  = '{3'd0, OP_R,  64'sd63,        5'd3, 5'd2, 5'd4,  1'b1, 32'h8B02FC64};
        vt[6]  = '{3'd0, OP_R,  64'sd64,        5'd3, 5'd2, 5'd4,  1'b0, 32'h0};
        vt[7]  = '{3'd0, OP_R,  -64'sd1,        5'd3, 5'd2, 5'd4,  1'b0, 32'h0};
        vt[8]  = '{3'd1, OP_I,  64'sd2047,      5'd1, 5'd0, 5'd2,  1'b1, 32'h911FFC22};
        vt[9]  = '{3'd1, OP_I,  -64'sd2048,     5'd0, 5'd0, 5'd0,  1'b1, 32'h91200000};
        vt[10] = '{3'd1, OP_I,  64'sd2048,      5'd0, 5'd0, 5'd0,  1'b0, 32'h0};
        vt[11] = '{3'd1, OP_I,  -64'sd2049,     5'd0, 5'd0, 5'd0,  1'b0, 32'h0};
        vt[12] = '{3'd4, OP_B,  64'sd33554431,  5'd0, 5'd0, 5'd0,  1'b1, 32'h15FFFFFF};
        vt[13] = '{3'd4, OP_B,  -64'sd33554432, 5'd0, 5'd0, 5'd0,  1'b1, 32'h16000000};
        vt[14] = '{3'd4, OP_B,  64'sd33554432,  5'd0, 5'd0, 5'd0,  1'b0, 32'h0};
        vt[15] = '{3'd3, OP_CB, 64'sd262143,    5'd0, 5'd0, 5'd0,  1'b1, 32'hB47FFFE0};
        vt[16] = '{3'd3, OP_CB, -64'sd262144,   5'd0, 5'd0, 5'd31, 1'b1, 32'hB480001F};
        vt[17] = '{3'd3, OP_CB, -64'sd262145,   5'd0, 5'd0, 5'd0,  1'b0, 32'h0};
        vt[18] = '{3'd5, OP_D,  64'sd0,         5'd0, 5'd0, 5'd0,  1'b0, 32'h0};
        vt[19] = '{3'd7, OP_D,  64'sd0,         5'd0, 5'd0, 5'd0,  1'b0, 32'h0};
        vt[20] = '{3'd2, OP_D,  64'sd255,       5'd0, 5'd0, 5'd1,  1'b1, 32'hF84FF001};

        // Reset state
        reset = 1'b0;
        clear = 1'b0;
        drive(1'b0, 3'd0, 11'd0, 64'sd0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("rst wr_en", wr_en, 0);
        chk("rst wr_addr", wr_addr, 0);
        chk("rst wr_data", wr_data, 0);
        chk("rst range_err", range_err, 0);
        chk("rst err_pulse", err_pulse, 0);
        chk("rst full", full, 0);
        chk("rst count", count, 0);
        chk("rst in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Directed vector table, each from a cleared encoder
        for (int i = 0; i < 21; i++) begin
            pulse_clear();
            drive(1'b1, vt[i].f, vt[i].op, vt[i].imm, vt[i].rn, vt[i].rm, vt[i].rd);
            step();
            in_valid = 1'b0;
            chk($sformatf("vec%0d wr_en", i), wr_en, vt[i].ok);
            chk($sformatf("vec%0d err_pulse", i), err_pulse, !vt[i].ok);
            chk($sformatf("vec%0d range_err", i), range_err, !vt[i].ok);
            chk($sformatf("vec%0d count", i), count, vt[i].ok ? 1 : 0);
            if (vt[i].ok) begin
                chk($sformatf("vec%0d wr_data", i), wr_data, vt[i].word);
                chk($sformatf("vec%0d wr_addr", i), wr_addr, 0);
            end
            step();
            chk($sformatf("vec%0d wr_en drop", i), wr_en, 0);
            chk($sformatf("vec%0d err_pulse drop", i), err_pulse, 0);
        end

        // Back-to-back D then I
        pulse_clear();
        drive(1'b1, 3'd2, OP_D, 64'sd23, 5'd0, 5'd0, 5'd1);
        step();
        chk("b2b d wr_en", wr_en, 1);
        chk("b2b d addr", wr_addr, 0);
        chk("b2b d data", wr_data, 32'hF8417001);
        drive(1'b1, 3'd1, OP_I, 64'sd23, 5'd1, 5'd0, 5'd1);
        step();
        in_valid = 1'b0;
        chk("b2b i wr_en", wr_en, 1);
        chk("b2b i addr", wr_addr, 1);
        chk("b2b i data", wr_data, 32'h91005C21);
        chk("b2b count", count, 2);

        // Error then sticky flag, then normal write after it
        drive(1'b1, 3'd2, OP_D, 64'sd256, 5'd0, 5'd0, 5'd1);
        step();
        chk("err wr_en", wr_en, 0);
        chk("err pulse", err_pulse, 1);
        chk("err count", count, 2);
        drive(1'b1, 3'd2, OP_D, -64'sd256, 5'd0, 5'd0, 5'd1);
        step();
        in_valid = 1'b0;
        chk("after err wr_en", wr_en, 1);
        chk("after err addr", wr_addr, 2);
        chk("after err data", wr_data, 32'hF8500001);
        chk("after err pulse", err_pulse, 0);
        chk("after err sticky", range_err, 1);

        // Fill to DEPTH with five back-to-back transfers
        pulse_clear();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd2, OP_D, longint'(i), 5'd0, 5'd0, 5'd1);
            #1;
            chk($sformatf("fill%0d in_ready", i), in_ready, i < 4);
            @(negedge clk);
            chk($sformatf("fill%0d wr_en", i), wr_en, i < 4);
            chk($sformatf("fill%0d count", i), count, (i < 4) ? i + 1 : 4);
            if (i < 4) chk($sformatf("fill%0d addr", i), wr_addr, i);
            chk($sformatf("fill%0d full", i), full, i >= 3);
        end
        in_valid = 1'b0;
        clear = 1'b1;
        #1;
        chk("full clear in_ready", in_ready, 0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("cleared full", full, 0);
        chk("cleared count", count, 0);
        chk("cleared in_ready", in_ready, 1);
        @(negedge clk);

        // Asynchronous reset during a write cycle
        drive(1'b1, 3'd2, OP_D, 64'sd999, 5'd0, 5'd0, 5'd1);
        step();
        drive(1'b1, 3'd2, OP_D, 64'sd5, 5'd0, 5'd0, 5'd1);
        step();
        in_valid = 1'b0;
        chk("pre-rst wr_en", wr_en, 1);
        chk("pre-rst range_err", range_err, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst wr_en", wr_en, 0);
        chk("midrst count", count, 0);
        chk("midrst range_err", range_err, 0);
        chk("midrst wr_data", wr_data, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Randomized run against the model
        m_count = 0;
        m_full  = 1'b0;
        m_rerr  = 1'b0;
        for (int c = 0; c < 600; c++) begin
            int     f, width, sel, ea;
            longint lo, hi, im;
            bit     clr, v, e_wr, e_err;
            logic [31:0] e_data;
            clr = ($urandom_range(0, 11) == 0);
            v   = ($urandom_range(0, 3) != 0);
            f   = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            case (f)
                0: width = 6;
                1: width = 12;
                2: width = 9;
                3: width = 19;
                default: width = 26;
            endcase
            if (f == 0) begin
                lo = 0;
                hi = 63;
            end else begin
                lo = -(longint'(1) << (width - 1));
                hi = (longint'(1) << (width - 1)) - 1;
            end
            sel = $urandom_range(0, 4);
            case (sel)
                0: im = {$urandom, $urandom};
                1: im = hi - 1 + longint'($urandom_range(0, 2));
                2: im = lo - 1 + longint'($urandom_range(0, 2));
                default: im = lo + longint'($urandom) % (hi - lo + 1);
            endcase
            clear = clr;
            drive(v, 3'(f), 11'($urandom), im, 5'($urandom), 5'($urandom), 5'($urandom));
            #1;
            chk($sformatf("rnd%0d in_ready", c), in_ready, !m_full && !clr);
            e_wr   = 1'b0;
            e_err  = 1'b0;
            e_data = 32'd0;
            ea     = 0;
            if (clr) begin
                m_count = 0;
                m_full  = 1'b0;
                m_rerr  = 1'b0;
            end else if (v && !m_full) begin
                model_encode(f, opcode, im, int'(rn), int'(rm), int'(rd), ok, w);
                if (ok) begin
                    e_wr    = 1'b1;
                    e_data  = w;
                    ea      = m_count;
                    m_count = m_count + 1;
                    if (m_count == DEPTH) m_full = 1'b1;
                end else begin
                    e_err  = 1'b1;
                    m_rerr = 1'b1;
                end
            end
            @(negedge clk);
            chk($sformatf("rnd%0d wr_en", c), wr_en, e_wr);
            chk($sformatf("rnd%0d err_pulse", c), err_pulse, e_err);
            chk($sformatf("rnd%0d range_err", c), range_err, m_rerr);
            chk($sformatf("rnd%0d full", c), full, m_full);
            chk($sformatf("rnd%0d count", c), count, m_count);
            if (e_wr) begin
                chk($sformatf("rnd%0d wr_addr", c), wr_addr, ea);
                chk($sformatf("rnd%0d wr_data", c), wr_data, e_data);
            end
        end
        clear    = 1'b0;
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
